cpu_prog_sequencer: RTL and testbench
=====================================

CPU_PROG_SEQUENCER -- requirements
Module: cpu_prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of program words; the address width is log2(DEPTH).
REQ-002 Parameter SETTLE, default 2, minimum 1: number of settle cycles between issuing PI and sampling the CPU outputs.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-005 Port load_en, input, 1: program-memory write strobe.
REQ-006 Port load_addr, input, 4: program-memory write address.
REQ-007 Port load_data, input, 10: instruction word to write.
REQ-008 Port prog_len, input, 5: number of words to run, 0..16.
REQ-009 Port start, input, 1: single-cycle run request.
REQ-010 Port PI, output, 10: instruction word driven to the CPU.
REQ-011 Port R_in, input, 5: CPU result.
REQ-012 Ports CF_in, SF_in, ZF_in, GF_in, input, 1 each: CPU flags.
REQ-013 Port res_valid, output, 1: a captured result is available.
REQ-014 Port res_ready, input, 1: the consumer accepts the result.
REQ-015 Port res_data, output, 9: {GF,ZF,SF,CF,R}.
REQ-016 Port res_idx, output, 4: program index of res_data.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port done, output, 1: one-cycle pulse at run completion.

Function
REQ-019 Program memory: DEPTH x 10 bits; written at the clk edge when load_en=1 and busy=0; load_en is ignored when busy=1.
REQ-020 FSM states: IDLE, ISSUE, SETTLE, OUT, DONE.
REQ-021 IDLE: start=1 with prog_len!=0 -> ISSUE with pc=0.
REQ-022 IDLE: start=1 with prog_len=0 -> DONE.
REQ-023 prog_len values greater than DEPTH are treated as DEPTH; the length is latched at start, so later changes have no effect on the run.
REQ-024 ISSUE lasts one cycle, drives PI=mem[pc], loads the settle counter with SETTLE-1, then goes to SETTLE.
REQ-025 SETTLE lasts exactly SETTLE cycles.
REQ-026 At the edge that leaves SETTLE, {GF_in,ZF_in,SF_in,CF_in,R_in} is registered into res_data, res_idx is set to pc, and the FSM enters OUT.
REQ-027 OUT: res_valid=1; res_data and res_idx are held stable until a clk edge with res_ready=1.
REQ-028 OUT acceptance edge (res_valid=1, res_ready=1): if pc = latched length-1 -> DONE; otherwise pc+1 and -> ISSUE.
REQ-029 Back-to-back acceptance is supported: res_ready may be held high continuously.
REQ-030 PI holds mem[pc] through ISSUE, SETTLE and OUT; PI=0 in IDLE and DONE.
REQ-031 DONE lasts one cycle with done=1, then -> IDLE; done=0 in all other states.
REQ-032 start is ignored whenever busy=1.
REQ-033 Per-instruction latency from ISSUE entry to res_valid is 1+SETTLE cycles; a full run with res_ready tied high takes len*(2+SETTLE)+1 cycles from start to the done pulse.
REQ-034 pc never wraps past the latched length-1.

Reset
REQ-035 rst_n=0 asynchronously forces: state=IDLE, pc=0, PI=0, res_valid=0, res_data=0, res_idx=0, busy=0, done=0.
REQ-036 Program memory is not cleared by reset; its contents persist across reset.
REQ-037 Reset asserted mid-run aborts the run with no done pulse; after release, a new start runs from pc=0.

Verification
REQ-038 Load 0010100000, 0100100100, 0100100011 at addresses 0..2, prog_len=3, SETTLE=2, res_ready=1, start -> PI shows each word for 4 cycles in order; res_idx 0,1,2; done pulses 13 cycles after start.
REQ-039 Hold res_ready=0 for 5 cycles while in OUT for index 1 -> res_valid, res_data and PI are held stable, pc does not advance, and the run resumes when res_ready returns high.
REQ-040 Drive R_in=10110, CF_in=1, SF_in=1, ZF_in=0, GF_in=0 during SETTLE -> res_data=0_0_1_1_10110.
REQ-041 prog_len=0 with start -> done pulses on the next cycle, no res_valid, PI stays 0.
REQ-042 load_en to address 1 during a run -> the write is ignored; a rerun issues the original word.
REQ-043 Pulse rst_n low during SETTLE of index 2 -> all outputs are 0 immediately; after release, start runs again from index 0 with the memory intact.

Source files
------------

// File: rtl/cpu_prog_sequencer.sv
// cpu_prog_sequencer: steps a loaded program through an external CPU one word at a time,
// capturing each settled result for a ready/valid consumer.
module cpu_prog_sequencer #(
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [9:0]                 load_data,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    output logic [9:0]                 PI,
    input  logic [4:0]                 R_in,
    input  logic                       CF_in,
    input  logic                       SF_in,
    input  logic                       ZF_in,
    input  logic                       GF_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [8:0]                 res_data,
    output logic [$clog2(DEPTH)-1:0]   res_idx,
    output logic                       busy,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_OUT, S_DONE} state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [LW-1:0]   len;
    logic [CW-1:0]   cnt;
    logic [9:0]      mem [DEPTH];

    // Memory has no reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (load_en && !busy) mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            len       <= '0;
            cnt       <= '0;
            PI        <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    len  <= prog_len > LW'(DEPTH) ? LW'(DEPTH) : prog_len;
                    pc   <= '0;
                    busy <= 1'b1;
                    if (prog_len != '0) begin
                        state <= S_ISSUE;
                        PI    <= mem[0];
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_SETTLE;
                    cnt   <= CW'(SETTLE - 1);
                end
                S_SETTLE: if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    state     <= S_OUT;
                    res_valid <= 1'b1;
                    res_data  <= {GF_in, ZF_in, SF_in, CF_in, R_in};
                    res_idx   <= pc;
                end
                S_OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    if ({1'b0, pc} == len - LW'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        PI    <= '0;
                    end else begin
                        state <= S_ISSUE;
                        pc    <= pc + AW'(1);
                        PI    <= mem[pc + AW'(1)];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// tb_cpu_prog_sequencer: randomized runs scored against a per-instruction timing/data model.
module tb_cpu_prog_sequencer;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n, load_en, start, res_ready;
    logic [3:0] load_addr, res_idx;
    logic [9:0] load_data, PI;
    logic [4:0] prog_len, R_in;
    logic       CF_in, SF_in, ZF_in, GF_in;
    logic       res_valid, busy, done;
    logic [8:0] res_data;
    logic [9:0] mem_sh [16];
    int         checks = 0, errors = 0, dt;

    cpu_prog_sequencer #(.DEPTH(16), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .PI(PI),
        .R_in(R_in), .CF_in(CF_in), .SF_in(SF_in), .ZF_in(ZF_in), .GF_in(GF_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic load_word(input int a, input logic [9:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = 4'(a); load_data = d;
        mem_sh[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready dropped for 5 cycles at index 1
    task automatic run(input int len_in, input int mode, input bit fixed, input bit poke,
                       input bit abort, output int done_t);
        int len, i, t, nv, stall;
        bit in_out, rdy_prev, fin;
        logic [8:0] cur, prev, exp_data;
        logic [9:0] exp_pi;
        len = len_in > 16 ? 16 : len_in;
        i = 0; t = -1; nv = 1 + SETTLE; stall = 0;
        in_out = 0; fin = 0; done_t = -1; exp_data = '0;
        @(negedge clk);
        prog_len = 5'(len_in); start = 1'b1;
        cur = fixed ? 9'b0_0_1_1_10110 : 9'($urandom);
        {GF_in, ZF_in, SF_in, CF_in, R_in} = cur;
        res_ready = mode == 1 ? 1'($urandom) : 1'b1;
        while (!fin && t < 600) begin
            prev = cur; rdy_prev = res_ready;
            @(negedge clk);
            t++; start = 1'b0; load_en = 1'b0;
            if (in_out && rdy_prev) begin
                in_out = 0; i++; nv = t + 1 + SETTLE;
            end
            if (!in_out && i < len && t == nv) begin
                in_out = 1; exp_data = prev;
                if (mode == 2 && i == 1) stall = 5;
            end
            exp_pi = i < len ? mem_sh[i] : '0;
            checks++;
            if (res_valid !== in_out) begin
                errors++; $display("FAIL valid t=%0d got %b exp %b", t, res_valid, in_out);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy t=%0d got %b exp 1", t, busy);
            end
            checks++;
            if (done !== (i == len)) begin
                errors++; $display("FAIL done t=%0d got %b exp %b", t, done, i == len);
            end
            checks++;
            if (PI !== exp_pi) begin
                errors++; $display("FAIL pi t=%0d got %b exp %b", t, PI, exp_pi);
            end
            if (in_out) begin
                checks++;
                if (res_data !== exp_data || res_idx !== 4'(i)) begin
                    errors++;
                    $display("FAIL result t=%0d got %b/%0d exp %b/%0d", t, res_data, res_idx, exp_data, i);
                end
            end
            if (i == len) begin
                fin = 1; done_t = t;
            end
            if (abort && i == 2 && !in_out && t == nv - 1) begin
                #2 rst_n = 1'b0;
                #1 checks++;
                if ({PI, res_valid, res_data, res_idx, busy, done} !== '0) begin
                    errors++;
                    $display("FAIL abort_zero got pi=%b v=%b d=%b idx=%0d busy=%b done=%b exp all 0",
                             PI, res_valid, res_data, res_idx, busy, done);
                end
                #1 rst_n = 1'b1;
                return;
            end
            if (poke && t == 1) begin
                load_en = 1'b1; load_addr = 4'd1; load_data = ~mem_sh[1];
            end
            prog_len = 5'($urandom);
            cur = fixed ? 9'b0_0_1_1_10110 : 9'($urandom);
            {GF_in, ZF_in, SF_in, CF_in, R_in} = cur;
            res_ready = mode == 1 ? ($urandom % 3 != 0) : mode == 2 ? (stall == 0) : 1'b1;
            if (stall > 0) stall--;
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL timeout got no done exp done within 600 cycles");
        end else begin
            @(negedge clk);
            if ({busy, done, res_valid, PI} !== '0) begin
                errors++;
                $display("FAIL idle_after got busy=%b done=%b v=%b pi=%b exp all 0", busy, done, res_valid, PI);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load_en = 0; start = 0; res_ready = 0; load_addr = 0; load_data = 0;
        prog_len = 0; {GF_in, ZF_in, SF_in, CF_in, R_in} = '0;
        #3 checks++;
        if ({PI, res_valid, res_data, res_idx, busy, done} !== '0) begin
            errors++; $display("FAIL reset got nonzero outputs exp all 0");
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed;
        load_word(0, 10'b0010100000);
        load_word(1, 10'b0100100100);
        load_word(2, 10'b0100100011);
        run(3, 0, 1, 0, 0, dt);
        checks++;
        if (dt !== 3 * (2 + SETTLE)) begin
            errors++; $display("FAIL run_latency got %0d exp %0d", dt, 3 * (2 + SETTLE));
        end
    endtask

    task automatic test_stall;
        run(3, 2, 0, 0, 0, dt);
        checks++;
        if (dt !== 3 * (2 + SETTLE) + 5) begin
            errors++; $display("FAIL stall_latency got %0d exp %0d", dt, 3 * (2 + SETTLE) + 5);
        end
    endtask

    task automatic test_zero_len;
        run(0, 0, 0, 0, 0, dt);
        checks++;
        if (dt !== 0) begin
            errors++; $display("FAIL zero_len got %0d exp 0", dt);
        end
    endtask

    task automatic test_load_ignored;
        run(3, 1, 0, 1, 0, dt);
        run(3, 0, 0, 0, 0, dt);
    endtask

    task automatic test_clamp;
        for (int a = 0; a < 16; a++) load_word(a, 10'($urandom));
        run(20, 0, 0, 0, 0, dt);
        checks++;
        if (dt !== 16 * (2 + SETTLE)) begin
            errors++; $display("FAIL clamp got %0d exp %0d", dt, 16 * (2 + SETTLE));
        end
        run(31, 1, 0, 0, 0, dt);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) run(int'($urandom_range(1, 16)), 1, 0, 0, 0, dt);
    endtask

    task automatic test_reset_midrun;
        run(5, 0, 0, 0, 1, dt);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_nodone got done=%b busy=%b exp 0/0", done, busy);
            end
        end
        run(4, 0, 0, 0, 0, dt);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_zero_len;
        test_load_ignored;
        test_clamp;
        test_random;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
